// File: rtl/icache_nway_plru_if.sv
// Fetch-side, invalidate and AXI read-address/read-data signals of the instruction cache.
// The cache attaches through the slave modport and its environment through the master modport.
interface icache_nway_plru_if;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cpu_uncached;
   logic        cpu_addr_ok;
   logic        cpu_data_ok;
   logic [31:0] cpu_rdata;
   logic        inv_req;
   logic        inv_busy;
   logic        mem_arvalid;
   logic [31:0] mem_araddr;
   logic [7:0]  mem_arlen;
   logic        mem_arready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_rlast;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   modport slave (
      input  cpu_req, cpu_addr, cpu_uncached, inv_req,
      input  mem_arready, mem_rvalid, mem_rdata, mem_rlast,
      output cpu_addr_ok, cpu_data_ok, cpu_rdata, inv_busy,
      output mem_arvalid, mem_araddr, mem_arlen, hit_count, miss_count
   );

   modport master (
      output cpu_req, cpu_addr, cpu_uncached, inv_req,
      output mem_arready, mem_rvalid, mem_rdata, mem_rlast,
      input  cpu_addr_ok, cpu_data_ok, cpu_rdata, inv_busy,
      input  mem_arvalid, mem_araddr, mem_arlen, hit_count, miss_count
   );
endinterface

// File: rtl/icache_nway_plru.sv
// N-way set-associative instruction cache with tree pseudo-LRU replacement,
// uncached single-word bypass and a one-set-per-cycle invalidate sweep.
//
// state   | meaning
// IDLE    | lookup; hits answered combinationally, inv_req has priority
// MISS_AR | line-refill AR held until mem_arready
// REFILL  | collecting line beats into the line buffer until mem_rlast
// COMMIT  | buffer, tag and valid written into the victim way
// UNC_AR  | single-word AR for an uncached fetch
// UNC_R   | waiting for the uncached beat, forwarded in its cycle
// INVAL   | clearing valid and PLRU of one set per cycle
module icache_nway_plru #(
   parameter int WAYS       = 4,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 16
) (
   input logic             clk,
   input logic             rst_n,
   icache_nway_plru_if.slave bus
);
   localparam int LVL    = $clog2(WAYS);
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int OFF_W  = WORD_W + 2;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 32 - IDX_W - OFF_W;

   typedef enum logic [2:0] {IDLE, MISS_AR, REFILL, COMMIT, UNC_AR, UNC_R, INVAL} state_t;

   state_t            state_q, state_d;
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-2:0]   plru_q  [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [31:0]       data_q  [SETS][WAYS][LINE_WORDS];
   logic [31:0]       buf_q   [LINE_WORDS];
   logic [WORD_W:0]   beat_q;
   logic [LVL-1:0]    victim_q;
   logic [IDX_W-1:0]  inv_idx_q;
   logic [31:0]       hit_cnt_q, miss_cnt_q;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WORD_W-1:0] req_word;
   logic              hit_any, inv_any;
   logic [LVL-1:0]    hit_way, inv_way;
   logic              do_hit, do_miss;
   logic              ok;
   logic [31:0]       rdata;
   logic              arvalid;
   logic [31:0]       araddr;
   logic [7:0]        arlen;
   logic              busy;

   // Tree PLRU: node n has children 2n+1 / 2n+2; a 0 bit points the victim at the lower half.
   function automatic logic [LVL-1:0] plru_victim(input logic [WAYS-2:0] bits);
      logic [LVL-1:0] w;
      int             node;
      logic           b;
      w = '0;
      for (int l = 0; l < LVL; l++) begin
         node = (1 << l) - 1 + int'(w >> (LVL - l));
         b    = 1'b0;
         for (int n = 0; n < WAYS - 1; n++)
            if (n == node) b = bits[n];
         w = w | (LVL'(b) << (LVL - 1 - l));
      end
      return w;
   endfunction

   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                  input logic [LVL-1:0] w);
      logic [WAYS-2:0] nb;
      logic [LVL-1:0]  t;
      int              node;
      nb = bits;
      for (int l = 0; l < LVL; l++) begin
         node = (1 << l) - 1 + int'(w >> (LVL - l));
         t    = w >> (LVL - 1 - l);
         for (int n = 0; n < WAYS - 1; n++)
            if (n == node) nb[n] = ~t[0];
      end
      return nb;
   endfunction

   assign req_tag  = bus.cpu_addr[31 -: TAG_W];
   assign req_idx  = bus.cpu_addr[OFF_W +: IDX_W];
   assign req_word = bus.cpu_addr[2 +: WORD_W];

   // Descending scan so the lowest matching / lowest invalid way wins.
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
            hit_any = 1'b1;
            hit_way = LVL'(w);
         end
         if (!valid_q[req_idx][w]) begin
            inv_any = 1'b1;
            inv_way = LVL'(w);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ok      = 1'b0;
      rdata   = '0;
      arvalid = 1'b0;
      araddr  = '0;
      arlen   = '0;
      busy    = 1'b0;
      do_hit  = 1'b0;
      do_miss = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.inv_req) begin
               state_d = INVAL;
            end else if (bus.cpu_req) begin
               if (bus.cpu_uncached) begin
                  state_d = UNC_AR;
               end else if (hit_any) begin
                  ok     = 1'b1;
                  rdata  = data_q[req_idx][hit_way][req_word];
                  do_hit = 1'b1;
               end else begin
                  do_miss = 1'b1;
                  state_d = MISS_AR;
               end
            end
         end
         MISS_AR: begin
            arvalid = 1'b1;
            araddr  = {bus.cpu_addr[31:OFF_W], {OFF_W{1'b0}}};
            arlen   = 8'(LINE_WORDS - 1);
            if (bus.mem_arready) state_d = REFILL;
         end
         REFILL: begin
            if (bus.mem_rvalid && bus.mem_rlast) state_d = COMMIT;
         end
         COMMIT: state_d = IDLE;
         UNC_AR: begin
            arvalid = 1'b1;
            araddr  = bus.cpu_addr;
            if (bus.mem_arready) state_d = UNC_R;
         end
         UNC_R: begin
            if (bus.mem_rvalid) begin
               ok      = 1'b1;
               rdata   = bus.mem_rdata;
               state_d = IDLE;
            end
         end
         INVAL: begin
            busy = 1'b1;
            if (inv_idx_q == IDX_W'(SETS - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         victim_q   <= '0;
         inv_idx_q  <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q <= state_d;
         if (do_hit) begin
            plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (do_miss) begin
            victim_q <= inv_any ? inv_way : plru_victim(plru_q[req_idx]);
            beat_q   <= '0;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
         end
         if (state_q == REFILL && bus.mem_rvalid && !beat_q[WORD_W])
            beat_q <= beat_q + 1'b1;
         if (state_q == COMMIT) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            plru_q[req_idx]            <= plru_touch(plru_q[req_idx], victim_q);
         end
         if (state_q == INVAL) begin
            valid_q[inv_idx_q] <= '0;
            plru_q[inv_idx_q]  <= '0;
            inv_idx_q          <= inv_idx_q + 1'b1;
         end
      end
   end

   // Line storage needs no reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (state_q == REFILL && bus.mem_rvalid && !beat_q[WORD_W])
         buf_q[beat_q[WORD_W-1:0]] <= bus.mem_rdata;
      if (state_q == COMMIT) begin
         tag_q[req_idx][victim_q] <= req_tag;
         for (int i = 0; i < LINE_WORDS; i++)
            data_q[req_idx][victim_q][i] <= buf_q[i];
      end
   end

   assign bus.cpu_addr_ok = ok;
   assign bus.cpu_data_ok = ok;
   assign bus.cpu_rdata   = rdata;
   assign bus.inv_busy    = busy;
   assign bus.mem_arvalid = arvalid;
   assign bus.mem_araddr  = araddr;
   assign bus.mem_arlen   = arlen;
   assign bus.hit_count   = hit_cnt_q;
   assign bus.miss_count  = miss_cnt_q;
endmodule

// File: tb/tb_icache_nway_plru.sv
// Directed and randomized bench for icache_nway_plru; a timestamp-based LRU-tree
// model predicts hits, victims, AXI traffic and counters.
module tb_icache_nway_plru;
   localparam int WAYS = 4;
   localparam int SETS = 64;
   localparam int LW   = 16;
   localparam int LINE_BYTES = LW * 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   icache_nway_plru_if bus ();

   icache_nway_plru #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int              nchk = 0;
   int              nfail = 0;
   bit              mv   [SETS][WAYS];
   logic [31:0]     mtag [SETS][WAYS];
   longint unsigned ts   [SETS][WAYS];
   longint unsigned now = 0;
   logic [31:0]     exp_hit = '0;
   logic [31:0]     exp_miss = '0;
   logic [31:0]     memw [logic [31:0]];
   logic            last_hit;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (memw.exists(a)) return memw[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic int set_of(input logic [31:0] a);
      return int'((a / LINE_BYTES) % SETS);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a);
      return a / (LINE_BYTES * SETS);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            mv[s][w] = 1'b0;
            ts[s][w] = 0;
         end
   endtask

   task automatic touch(input int s, input int w);
      now++;
      ts[s][w] = now;
   endtask

   // Lowest invalid way, else descend the binary split of the ways, at each level
   // taking the half whose most recent access is older (ties go low).
   function automatic int model_victim(input int s);
      int lo, size, half;
      longint unsigned ml, mr;
      for (int w = 0; w < WAYS; w++)
         if (!mv[s][w]) return w;
      lo = 0;
      size = WAYS;
      while (size > 1) begin
         half = size / 2;
         ml = 0;
         mr = 0;
         for (int i = 0; i < half; i++) begin
            if (ts[s][lo + i] > ml) ml = ts[s][lo + i];
            if (ts[s][lo + half + i] > mr) mr = ts[s][lo + half + i];
         end
         if (ml > mr) lo = lo + half;
         size = half;
      end
      return lo;
   endfunction

   task automatic cached(input logic [31:0] a, input int ar_delay);
      int s, way, beat;
      logic [31:0] base;
      s = set_of(a);
      base = a - (a % LINE_BYTES);
      way = -1;
      for (int w = WAYS - 1; w >= 0; w--)
         if (mv[s][w] && mtag[s][w] == tag_of(a)) way = w;
      @(negedge clk);
      bus.cpu_req = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_uncached = 1'b0;
      #1;
      last_hit = bus.cpu_data_ok;
      if (way >= 0) begin
         chk("hit_data_ok", 32'(bus.cpu_data_ok), 32'd1);
         chk("hit_addr_ok", 32'(bus.cpu_addr_ok), 32'd1);
         chk("hit_rdata", bus.cpu_rdata, mem_word(a));
      end else begin
         chk("miss_data_ok", 32'(bus.cpu_data_ok), 32'd0);
         way = model_victim(s);
         exp_miss = sat_inc(exp_miss);
         @(negedge clk);
         for (int c = 0; c <= ar_delay; c++) begin
            bus.mem_arready = (c == ar_delay);
            #1;
            chk("ar_valid", 32'(bus.mem_arvalid), 32'd1);
            chk("ar_addr", bus.mem_araddr, base);
            chk("ar_len", 32'(bus.mem_arlen), 32'(LW - 1));
            chk("ar_no_data", 32'(bus.cpu_data_ok), 32'd0);
            @(negedge clk);
         end
         bus.mem_arready = 1'b0;
         beat = 0;
         while (beat < LW) begin
            if ($urandom_range(0, 3) == 0) begin
               bus.mem_rvalid = 1'b0;
               bus.mem_rlast = 1'b0;
            end else begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata = mem_word(base + 32'(4 * beat));
               bus.mem_rlast = (beat == LW - 1);
               beat++;
            end
            #1;
            chk("refill_no_data", 32'(bus.cpu_data_ok), 32'd0);
            chk("refill_ar_low", 32'(bus.mem_arvalid), 32'd0);
            @(negedge clk);
         end
         bus.mem_rvalid = 1'b0;
         bus.mem_rlast = 1'b0;
         #1;
         chk("commit_no_data", 32'(bus.cpu_data_ok), 32'd0);
         mv[s][way] = 1'b1;
         mtag[s][way] = tag_of(a);
         touch(s, way);
         @(negedge clk);
         #1;
         chk("fill_hit_ok", 32'(bus.cpu_data_ok), 32'd1);
         chk("fill_hit_rdata", bus.cpu_rdata, mem_word(a));
      end
      exp_hit = sat_inc(exp_hit);
      touch(s, way);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      #1;
      chk("hit_count", bus.hit_count, exp_hit);
      chk("miss_count", bus.miss_count, exp_miss);
   endtask

   task automatic uncached(input logic [31:0] a, input logic [31:0] d, input int ar_delay, input int r_gap);
      @(negedge clk);
      bus.cpu_req = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_uncached = 1'b1;
      #1;
      chk("unc_idle_no_data", 32'(bus.cpu_data_ok), 32'd0);
      @(negedge clk);
      for (int c = 0; c <= ar_delay; c++) begin
         bus.mem_arready = (c == ar_delay);
         #1;
         chk("unc_ar_valid", 32'(bus.mem_arvalid), 32'd1);
         chk("unc_ar_addr", bus.mem_araddr, a);
         chk("unc_ar_len", 32'(bus.mem_arlen), 32'd0);
         @(negedge clk);
      end
      bus.mem_arready = 1'b0;
      for (int c = 0; c < r_gap; c++) begin
         #1;
         chk("unc_wait_no_data", 32'(bus.cpu_data_ok), 32'd0);
         @(negedge clk);
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = d;
      bus.mem_rlast = 1'b1;
      #1;
      chk("unc_data_ok", 32'(bus.cpu_data_ok), 32'd1);
      chk("unc_addr_ok", 32'(bus.cpu_addr_ok), 32'd1);
      chk("unc_rdata", bus.cpu_rdata, d);
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rlast = 1'b0;
      bus.cpu_req = 1'b0;
      bus.cpu_uncached = 1'b0;
      #1;
      chk("unc_hit_count", bus.hit_count, exp_hit);
      chk("unc_miss_count", bus.miss_count, exp_miss);
   endtask

   task automatic invalidate(input logic [31:0] competing_addr);
      int cyc, ok_seen;
      @(negedge clk);
      bus.inv_req = 1'b1;
      bus.cpu_req = 1'b1;
      bus.cpu_addr = competing_addr;
      bus.cpu_uncached = 1'b0;
      #1;
      chk("inv_priority", 32'(bus.cpu_data_ok), 32'd0);
      @(negedge clk);
      bus.inv_req = 1'b0;
      bus.cpu_req = 1'b0;
      cyc = 0;
      ok_seen = 0;
      #1;
      while (bus.inv_busy === 1'b1 && cyc < 4 * SETS) begin
         if (bus.cpu_data_ok !== 1'b0) ok_seen++;
         cyc++;
         @(negedge clk);
         #1;
      end
      chk("inv_busy_cycles", 32'(cyc), 32'(SETS));
      chk("inv_no_data", 32'(ok_seen), 32'd0);
      model_clear();
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int r;
      bus.cpu_req = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_uncached = 1'b0;
      bus.inv_req = 1'b0;
      bus.mem_arready = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_rlast = 1'b0;
      model_clear();

      // Reset values
      #12;
      chk("rst_addr_ok", 32'(bus.cpu_addr_ok), 32'd0);
      chk("rst_data_ok", 32'(bus.cpu_data_ok), 32'd0);
      chk("rst_rdata", bus.cpu_rdata, 32'd0);
      chk("rst_arvalid", 32'(bus.mem_arvalid), 32'd0);
      chk("rst_araddr", bus.mem_araddr, 32'd0);
      chk("rst_arlen", 32'(bus.mem_arlen), 32'd0);
      chk("rst_inv_busy", 32'(bus.inv_busy), 32'd0);
      chk("rst_hit_count", bus.hit_count, 32'd0);
      chk("rst_miss_count", bus.miss_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cold miss with line data 0x100+i
      for (int i = 0; i < LW; i++) memw[32'h0000_1040 + 32'(4 * i)] = 32'h100 + 32'(i);
      cached(32'h0000_1044, 2);
      chk("cold_last_hit", 32'(last_hit), 32'd0);
      chk("cold_hits", bus.hit_count, 32'd1);
      chk("cold_misses", bus.miss_count, 32'd1);

      // Fill index 1 with tags 0..3, touch 0,2,1, then tag 4 evicts tag 3
      for (int t = 0; t < 4; t++) cached(32'(t * LINE_BYTES * SETS + LINE_BYTES), 0);
      cached(32'(0 * LINE_BYTES * SETS + LINE_BYTES + 8), 0);
      chk("t0_hit", 32'(last_hit), 32'd1);
      cached(32'(2 * LINE_BYTES * SETS + LINE_BYTES + 4), 0);
      cached(32'(1 * LINE_BYTES * SETS + LINE_BYTES + 12), 0);
      cached(32'(4 * LINE_BYTES * SETS + LINE_BYTES), 1);
      chk("t4_miss", 32'(last_hit), 32'd0);
      cached(32'(0 * LINE_BYTES * SETS + LINE_BYTES), 0);
      chk("t0_kept", 32'(last_hit), 32'd1);
      cached(32'(1 * LINE_BYTES * SETS + LINE_BYTES), 0);
      chk("t1_kept", 32'(last_hit), 32'd1);
      cached(32'(2 * LINE_BYTES * SETS + LINE_BYTES), 0);
      chk("t2_kept", 32'(last_hit), 32'd1);
      cached(32'(3 * LINE_BYTES * SETS + LINE_BYTES), 0);
      chk("t3_evicted", 32'(last_hit), 32'd0);

      // Uncached bypass
      uncached(32'h1FC0_0008, 32'hDEAD_BEEF, 1, 2);

      // AR stalled for 10 cycles
      cached(32'h0002_0000, 10);

      // Invalidate, then a previously cached line misses again
      invalidate(32'h0000_1044);
      cached(32'h0000_1044, 0);
      chk("post_inv_miss", 32'(last_hit), 32'd0);

      // Randomized mix on a few conflicting sets
      for (int n = 0; n < 220; n++) begin
         r = int'($urandom_range(0, 39));
         if (r == 0) begin
            invalidate($urandom());
         end else if (r < 6) begin
            a = $urandom() & 32'hFFFF_FFFC;
            uncached(a, $urandom(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end else begin
            case ($urandom_range(0, 3))
               0: a = 32'(0 * LINE_BYTES);
               1: a = 32'(1 * LINE_BYTES);
               2: a = 32'(2 * LINE_BYTES);
               default: a = 32'((SETS - 1) * LINE_BYTES);
            endcase
            a = a + 32'($urandom_range(0, 5)) * 32'(LINE_BYTES * SETS) + 32'(4 * $urandom_range(0, LW - 1));
            cached(a, int'($urandom_range(0, 3)));
         end
      end

      // Reset in the middle of a refill
      cached(32'h3000_0100, 0);
      @(negedge clk);
      bus.cpu_req = 1'b1;
      bus.cpu_addr = 32'h4000_0000;
      bus.cpu_uncached = 1'b0;
      @(negedge clk);
      bus.mem_arready = 1'b1;
      @(negedge clk);
      bus.mem_arready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata = 32'(i);
         @(negedge clk);
      end
      bus.mem_rvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstmid_arvalid", 32'(bus.mem_arvalid), 32'd0);
      chk("rstmid_data_ok", 32'(bus.cpu_data_ok), 32'd0);
      chk("rstmid_hit_count", bus.hit_count, 32'd0);
      chk("rstmid_miss_count", bus.miss_count, 32'd0);
      bus.cpu_req = 1'b0;
      model_clear();
      exp_hit = '0;
      exp_miss = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cached(32'h3000_0100, 0);
      chk("rstmid_old_miss", 32'(last_hit), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
